// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory masters, the arbiter and the single-port memory.
// The arbiter takes the slave view; the masters and the memory sit on the master view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              m0_req;
    logic              m0_we;
    logic              m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        owner;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_we, mem_wdata, owner
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_we, mem_wdata, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a synchronous-read single-port memory, with
// capped locked bursts and a one-cycle rvalid strobe per master.
module mem_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 8
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST - 1);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e          state_q, state_d;
    logic            last_owner_q, last_owner_d;
    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
    logic            rvalid0_q, rvalid0_d;
    logic            rvalid1_q, rvalid1_d;

    logic              gnt0, gnt1, xfer;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    assign gnt0 = (state_q == StOwn0);
    assign gnt1 = (state_q == StOwn1);
    assign xfer = (gnt0 & bus.m0_req) | (gnt1 & bus.m1_req);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.m0_req && bus.m1_req) begin
                    state_d = last_owner_q ? StOwn0 : StOwn1;
                end else if (bus.m0_req) begin
                    state_d = StOwn0;
                end else if (bus.m1_req) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!bus.m0_req) begin
                    state_d = bus.m1_req ? StOwn1 : StIdle;
                end else if (bus.m1_req && (!bus.m0_lock || burst_cnt_q == BurstMax)) begin
                    state_d = StOwn1;
                end
            end
            StOwn1: begin
                if (!bus.m1_req) begin
                    state_d = bus.m0_req ? StOwn0 : StIdle;
                end else if (bus.m0_req && (!bus.m1_lock || burst_cnt_q == BurstMax)) begin
                    state_d = StOwn0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Dropping to idle keeps last_owner so the next tie still alternates.
        if (state_d != state_q) begin
            burst_cnt_d = '0;
            if (state_d == StOwn0) begin
                last_owner_d = 1'b0;
            end else if (state_d == StOwn1) begin
                last_owner_d = 1'b1;
            end
        end else if (xfer && burst_cnt_q != BurstMax) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    assign rvalid0_d = gnt0 & bus.m0_req & ~bus.m0_we;
    assign rvalid1_d = gnt1 & bus.m1_req & ~bus.m1_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
        end
    end

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        if (gnt0) begin
            addr_sel  = bus.m0_addr;
            wdata_sel = bus.m0_wdata;
        end else if (gnt1) begin
            addr_sel  = bus.m1_addr;
            wdata_sel = bus.m1_wdata;
        end
    end

    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;
    assign bus.mem_we    = (gnt0 & bus.m0_req & bus.m0_we) | (gnt1 & bus.m1_req & bus.m1_we);
    assign bus.owner     = {gnt1, gnt0};

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m1_rvalid = rvalid1_q;
    assign bus.m0_rdata  = rvalid0_q ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = rvalid1_q ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand sequences for
// locked bursts, uncontended parking and reset during an outstanding read.
module tb_mem_arbiter;
    logic clk;
    logic rst;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    mem_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .MAX_BURST(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model; a read in the same cycle as a write sees old data.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct packed {
        logic        rst;
        logic        r0, w0, l0;
        logic [7:0]  a0;
        logic [15:0] d0;
        logic        r1, w1, l1;
        logic [7:0]  a1;
        logic [15:0] d1;
        logic        g0, g1, v0, v1, we;
        logic [1:0]  own;
        logic [7:0]  maddr;
        logic [15:0] mwd, rd0, rd1;
    } vec_t;

    localparam int NumVec = 17;
    vec_t vec [NumVec];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        rst          = v.rst;
        bus.m0_req   = v.r0;
        bus.m0_we    = v.w0;
        bus.m0_lock  = v.l0;
        bus.m0_addr  = v.a0;
        bus.m0_wdata = v.d0;
        bus.m1_req   = v.r1;
        bus.m1_we    = v.w1;
        bus.m1_lock  = v.l1;
        bus.m1_addr  = v.a1;
        bus.m1_wdata = v.d1;
    endtask

    logic [63:0] act_o, exp_o;
    int n_xfer, g1_cyc;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        // inputs: rst, m0 {req,we,lock,addr,wdata}, m1 {req,we,lock,addr,wdata}
        // expect: g0,g1,rv0,rv1,mem_we,owner,mem_addr,mem_wdata,rdata0,rdata1
        vec[0]  = '{1'b0, 1,0,0, 8'h00, 16'h0000, 1,0,0, 8'h00, 16'h0000,
                    0,0,0,0,0, 2'b00, 8'h00, 16'h0000, 16'h0000, 16'h0000};
        vec[1]  = vec[0];
        vec[2]  = '{1'b1, 1,0,0, 8'h00, 16'h0000, 1,0,0, 8'h00, 16'h0000,
                    0,0,0,0,0, 2'b00, 8'h00, 16'h0000, 16'h0000, 16'h0000};
        vec[3]  = '{1'b1, 0,0,0, 8'h00, 16'h0000, 0,0,0, 8'h00, 16'h0000,
                    1,0,0,0,0, 2'b01, 8'h00, 16'h0000, 16'h0000, 16'h0000};
        vec[4]  = '{1'b1, 0,0,0, 8'h00, 16'h0000, 1,1,0, 8'h10, 16'hBEEF,
                    0,0,0,0,0, 2'b00, 8'h00, 16'h0000, 16'h0000, 16'h0000};
        vec[5]  = '{1'b1, 0,0,0, 8'h00, 16'h0000, 1,1,0, 8'h10, 16'hBEEF,
                    0,1,0,0,1, 2'b10, 8'h10, 16'hBEEF, 16'h0000, 16'h0000};
        vec[6]  = '{1'b1, 0,0,0, 8'h00, 16'h0000, 1,0,0, 8'h10, 16'h0000,
                    0,1,0,0,0, 2'b10, 8'h10, 16'h0000, 16'h0000, 16'h0000};
        vec[7]  = '{1'b1, 0,0,0, 8'h00, 16'h0000, 0,0,0, 8'h00, 16'h0000,
                    0,1,0,1,0, 2'b10, 8'h00, 16'h0000, 16'h0000, 16'hBEEF};
        vec[8]  = '{1'b1, 0,0,0, 8'h00, 16'h0000, 0,0,0, 8'h00, 16'h0000,
                    0,0,0,0,0, 2'b00, 8'h00, 16'h0000, 16'h0000, 16'h0000};
        vec[9]  = '{1'b1, 1,0,0, 8'h10, 16'h0000, 1,1,0, 8'h20, 16'h1234,
                    0,0,0,0,0, 2'b00, 8'h00, 16'h0000, 16'h0000, 16'h0000};
        vec[10] = '{1'b1, 1,0,0, 8'h10, 16'h0000, 1,1,0, 8'h20, 16'h1234,
                    1,0,0,0,0, 2'b01, 8'h10, 16'h0000, 16'h0000, 16'h0000};
        vec[11] = '{1'b1, 1,0,0, 8'h10, 16'h0000, 1,1,0, 8'h20, 16'h1234,
                    0,1,1,0,1, 2'b10, 8'h20, 16'h1234, 16'hBEEF, 16'h0000};
        vec[12] = '{1'b1, 1,0,0, 8'h10, 16'h0000, 1,1,0, 8'h20, 16'h1234,
                    1,0,0,0,0, 2'b01, 8'h10, 16'h0000, 16'h0000, 16'h0000};
        vec[13] = '{1'b1, 1,0,0, 8'h10, 16'h0000, 1,0,0, 8'h20, 16'h0000,
                    0,1,1,0,0, 2'b10, 8'h20, 16'h0000, 16'hBEEF, 16'h0000};
        vec[14] = '{1'b1, 1,0,0, 8'h10, 16'h0000, 1,0,0, 8'h20, 16'h0000,
                    1,0,0,1,0, 2'b01, 8'h10, 16'h0000, 16'h0000, 16'h1234};
        vec[15] = '{1'b1, 0,0,0, 8'h00, 16'h0000, 0,0,0, 8'h00, 16'h0000,
                    0,1,1,0,0, 2'b10, 8'h00, 16'h0000, 16'hBEEF, 16'h0000};
        vec[16] = vec[8];

        drive(vec[0]);
        for (int i = 0; i < NumVec; i++) begin
            @(negedge clk);
            drive(vec[i]);
            #1;
            act_o = {1'b0, bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_we,
                     bus.owner, bus.mem_addr, bus.mem_wdata, bus.m0_rdata, bus.m1_rdata};
            exp_o = {1'b0, vec[i].g0, vec[i].g1, vec[i].v0, vec[i].v1, vec[i].we,
                     vec[i].own, vec[i].maddr, vec[i].mwd, vec[i].rd0, vec[i].rd1};
            chk($sformatf("vec%0d", i), act_o, exp_o);
        end

        // Locked burst under contention: m0 holds for exactly MAX_BURST transfers.
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_lock = 1'b1; bus.m0_addr = 8'h10;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_lock = 1'b0; bus.m1_addr = 8'h20;
        n_xfer = 0;
        g1_cyc = -1;
        for (int c = 0; c < 20 && g1_cyc < 0; c++) begin
            cyc();
            if (bus.m0_gnt && bus.m0_req) n_xfer++;
            if (bus.m1_gnt) g1_cyc = c;
        end
        chk("burst_m0_xfers", 64'(n_xfer), 64'd8);
        chk("burst_handover_cycle", 64'(g1_cyc), 64'd8);

        bus.m0_req = 1'b0; bus.m0_lock = 1'b0; bus.m1_req = 1'b0;
        cyc();
        chk("burst_release_idle", 64'(bus.owner), 64'd0);

        // Uncontended parking with lock=0, then m1 steals on the next cycle.
        bus.m0_req = 1'b1;
        n_xfer = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (bus.m0_gnt && bus.m0_req) n_xfer++;
        end
        chk("park_xfers", 64'(n_xfer), 64'd20);
        bus.m1_req = 1'b1;
        cyc();
        chk("park_m1_gnt", 64'({bus.m0_gnt, bus.m1_gnt}), 64'b01);

        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        cyc();
        chk("pre_reset_idle", 64'(bus.owner), 64'd0);

        // Reset arrives before the read's rvalid edge: no strobe may escape.
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 8'h10;
        cyc();
        chk("rst_read_gnt", 64'(bus.m0_gnt), 64'd1);
        #3 rst = 1'b0;
        #2;
        chk("rst_rvalid_edge", 64'({bus.m0_rvalid, bus.m0_gnt, bus.owner}), 64'd0);
        cyc();
        chk("rst_rvalid_held", 64'({bus.m0_rvalid, bus.m0_gnt, bus.mem_we, bus.owner}), 64'd0);
        chk("rst_rdata", 64'(bus.m0_rdata), 64'd0);
        rst = 1'b1;
        bus.m0_req = 1'b0;
        cyc();
        chk("rst_release_idle", 64'({bus.m0_rvalid, bus.owner}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
